// File: rtl/conv_host_mem_if.sv
// Bundle of CONV port signals between the accelerator/host side (master)
// and the host memory responder (slave).
interface conv_host_mem_if #(
  parameter int DW = 20,
  parameter int AW = 12
);
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          start;
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;
  logic          dump_req;
  logic [2:0]    dump_sel;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_valid;
  logic [2:0]    layer_written;
  logic [31:0]   run_cycles;
  logic          timeout;
  logic [1:0]    state_o;

  modport master (
    output ld_valid, ld_addr, ld_data, start, busy, iaddr,
    output cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
    output dump_req, dump_sel, dump_addr,
    input  ready, idata, cdata_rd, dump_data, dump_valid,
    input  layer_written, run_cycles, timeout, state_o
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, start, busy, iaddr,
    input  cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
    input  dump_req, dump_sel, dump_addr,
    output ready, idata, cdata_rd, dump_data, dump_valid,
    output layer_written, run_cycles, timeout, state_o
  );
endinterface

// File: rtl/conv_host_mem.sv
// Host-side responder for the CONV bus: image ROM, five csel-banked result
// memories, run sequencing with cycle count/timeout, and a readback port.
module conv_host_mem #(
  parameter int          DW      = 20,
  parameter int          AW      = 12,
  parameter logic [31:0] TIMEOUT = 32'd5000000
) (
  input  logic           clk,
  input  logic           reset,
  conv_host_mem_if.slave bus
);
  localparam int NBANK     = 5;
  localparam int IMG_DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  function automatic int bank_depth(input int idx);
    case (idx)
      0, 1:    return 4096;
      2, 3:    return 1024;
      default: return 2048;
    endcase
  endfunction

  state_t           state_reg, state_next;
  logic             ready, host_phase, in_run, arm_entry;
  logic [31:0]      run_cycles_reg;
  logic             timeout_reg;
  logic [2:0]       layer_written_reg;
  logic [NBANK-1:0] write_hit;
  logic [DW-1:0]    idata_reg;
  logic [2:0]       rd_sel_reg, dump_sel_reg;
  logic             dump_valid_reg;
  logic [DW-1:0]    rd_word   [NBANK];
  logic [DW-1:0]    dump_word [NBANK];
  logic [DW-1:0]    cdata_rd, dump_data;
  logic [DW-1:0]    image_mem [IMG_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = ARM;
      ARM:     if (bus.busy) state_next = RUN;
      RUN:     if (!bus.busy || run_cycles_reg == TIMEOUT) state_next = DONE;
      DONE:    if (bus.start) state_next = ARM;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    host_phase = 1'b0;
    in_run     = 1'b0;
    arm_entry  = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        host_phase = 1'b1;
        arm_entry  = bus.start;
      end
      ARM:     ready  = 1'b1;
      RUN:     in_run = 1'b1;
      default: ;
    endcase
  end

  // The ARM->RUN edge already samples busy high, so it counts as the first busy cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cycles_reg    <= '0;
      timeout_reg       <= 1'b0;
      layer_written_reg <= '0;
    end else if (arm_entry) begin
      run_cycles_reg    <= '0;
      timeout_reg       <= 1'b0;
      layer_written_reg <= '0;
    end else begin
      if (state_reg == ARM && bus.busy) begin
        run_cycles_reg <= 32'd1;
      end
      if (in_run && bus.busy) begin
        if (run_cycles_reg == TIMEOUT) timeout_reg <= 1'b1;
        else                           run_cycles_reg <= run_cycles_reg + 32'd1;
      end
      layer_written_reg <= layer_written_reg |
        {write_hit[4], write_hit[3] | write_hit[2], write_hit[1] | write_hit[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (host_phase && bus.ld_valid) image_mem[bus.ld_addr] <= bus.ld_data;
  end

  // Falling-edge read gives CONV its data before the next rising edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset)       idata_reg <= '0;
    else if (in_run) idata_reg <= image_mem[bus.iaddr];
    else             idata_reg <= '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBANK; gi++) begin : g_bank
      localparam int DEPTH = bank_depth(gi);
      localparam int ABITS = $clog2(DEPTH);
      logic [DW-1:0] mem [DEPTH];
      logic [DW-1:0] rd_q, dump_q;
      logic          bank_sel;

      assign bank_sel      = (bus.csel == 3'(gi + 1));
      assign write_hit[gi] = in_run && bus.cwr && bank_sel && (int'(bus.caddr_wr) < DEPTH);

      always_ff @(posedge clk) begin
        if (write_hit[gi]) mem[bus.caddr_wr[ABITS-1:0]] <= bus.cdata_wr;
      end

      always_ff @(negedge clk) begin
        if (in_run && bus.crd && bank_sel)
          rd_q <= (int'(bus.caddr_rd) < DEPTH) ? mem[bus.caddr_rd[ABITS-1:0]] : '0;
      end

      always_ff @(posedge clk) begin
        if (host_phase && bus.dump_req && bus.dump_sel == 3'(gi + 1))
          dump_q <= (int'(bus.dump_addr) < DEPTH) ? mem[bus.dump_addr[ABITS-1:0]] : '0;
      end

      assign rd_word[gi]   = rd_q;
      assign dump_word[gi] = dump_q;
    end
  endgenerate

  // A bad csel leaves rd_sel_reg untouched, so cdata_rd holds its last value.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      rd_sel_reg <= '0;
    end else if (in_run && bus.crd && bus.csel >= 3'd1 && bus.csel <= 3'd5) begin
      rd_sel_reg <= bus.csel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dump_valid_reg <= 1'b0;
      dump_sel_reg   <= '0;
    end else begin
      dump_valid_reg <= host_phase && bus.dump_req;
      if (host_phase && bus.dump_req) dump_sel_reg <= bus.dump_sel;
    end
  end

  always_comb begin
    cdata_rd  = '0;
    dump_data = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (rd_sel_reg == 3'(i + 1))   cdata_rd  = rd_word[i];
      if (dump_sel_reg == 3'(i + 1)) dump_data = dump_word[i];
    end
  end

  assign bus.ready         = ready;
  assign bus.idata         = idata_reg;
  assign bus.cdata_rd      = cdata_rd;
  assign bus.dump_data     = dump_data;
  assign bus.dump_valid    = dump_valid_reg;
  assign bus.layer_written = layer_written_reg;
  assign bus.run_cycles    = run_cycles_reg;
  assign bus.timeout       = timeout_reg;
  assign bus.state_o       = state_reg;
endmodule
